// File: rtl/wait_state_memory.sv
// wait_state_memory: single-port, word-addressed RAM on a shared tristate bus.
// A request is accepted when CS is seen high in IDLE. After WAIT_CYCLES extra
// edges the access is performed, READY rises, and READY stays high until the
// master drops CS. Addresses at or above DEPTH complete with ERR set and leave
// the RAM untouched. Read data is driven onto Mem_Bus only in DONE, only for a
// read, and only while CS is still high.
module wait_state_memory #(
  parameter int DATA_W      = 32,  // multiple of 8
  parameter int DEPTH       = 128,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 2    // 0..15
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                CS,
  input  logic                WE,
  input  logic [DATA_W/8-1:0] BE,
  input  logic [ADDR_W-1:0]   ADDR,
  inout  wire  [DATA_W-1:0]   Mem_Bus,
  output logic                READY,
  output logic                ERR
);

  localparam int NB     = DATA_W / 8;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit on the depth constant keeps the range compare exact even
  // when DEPTH equals 2**ADDR_W.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [NB-1:0]       be_q, be_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;

  // Access operands. In IDLE they come straight from the pins, so that a
  // zero-wait access can happen on the same edge that accepts the request.
  // In every other state they come from the registered copies.
  logic                acc_we;
  logic [NB-1:0]       acc_be;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic                acc_in_range;
  logic [MEM_AW-1:0]   acc_idx;
  logic                access;
  logic                mem_wr;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  // Select access operands: live pins while idle, latched values afterwards.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_we    = WE;
      acc_be    = BE;
      acc_addr  = ADDR;
      acc_wdata = Mem_Bus;
    end else begin
      acc_we    = we_q;
      acc_be    = be_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  assign acc_in_range = ({1'b0, acc_addr} < DEPTH_EXT);
  assign acc_idx      = acc_addr[MEM_AW-1:0];

  // Next state for the FSM and the request/response registers.
  always_comb begin
    // NOTE: every signal gets a default first, so a branch that leaves one
    // unassigned holds the register value instead of inferring a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_d = ready_q;
    err_d   = err_q;
    access  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (CS) begin
          we_d    = acc_we;
          be_d    = acc_be;
          addr_d  = acc_addr;
          wdata_d = acc_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_DONE;
            access  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end

      ST_WAIT: begin
        // Losing CS takes priority, even on the edge that would complete.
        if (!CS) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_DONE: begin
        if (!CS) begin
          state_d = ST_IDLE;
          ready_d = 1'b0;
          err_d   = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b0;
        err_d   = 1'b0;
      end
    endcase

    if (access) begin
      ready_d = 1'b1;
      err_d   = !acc_in_range;
      if (!acc_in_range) begin
        rdata_d = '0;
      end else if (!acc_we) begin
        rdata_d = mem_q[acc_idx];
      end
    end
  end

  assign mem_wr = access && acc_in_range && acc_we;

  // Control and datapath registers. Reset abandons any transaction in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: state registers use non-blocking assignments so that every block
    // sampling them at this edge sees the old value, independent of order.
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // RAM array: byte-lane writes on the completing edge.
  // NOTE: the array has no reset. Contents survive RST_N, and leaving the
  // reset off lets the array map onto plain RAM.
  always_ff @(posedge CLK) begin
    if (mem_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (acc_be[i]) begin
          mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  assign READY   = ready_q;
  assign ERR     = err_q;
  assign Mem_Bus = (state_q == ST_DONE && !we_q && CS) ? rdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_wait_state_memory.sv
// Bench for wait_state_memory. Two instances are exercised: WAIT_CYCLES=2 and
// WAIT_CYCLES=0. Drivers push the expected response for each request into a
// per-instance queue. Monitors pop an entry on every READY rising edge and
// compare ERR and, for reads, the data on the bus.
module tb_wait_state_memory;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]  cs, we, men, ready, err;
  logic [3:0]  be   [2];
  logic [31:0] addr [2];
  logic [31:0] mdrv [2];
  wire  [31:0] bus0, bus1;

  assign bus0 = men[0] ? mdrv[0] : 'z;
  assign bus1 = men[1] ? mdrv[1] : 'z;

  wait_state_memory #(.DATA_W(32), .DEPTH(128), .ADDR_W(32), .WAIT_CYCLES(2)) u_dut_w2 (
    .CLK(clk), .RST_N(rst_n), .CS(cs[0]), .WE(we[0]), .BE(be[0]), .ADDR(addr[0]),
    .Mem_Bus(bus0), .READY(ready[0]), .ERR(err[0])
  );

  wait_state_memory #(.DATA_W(32), .DEPTH(128), .ADDR_W(32), .WAIT_CYCLES(0)) u_dut_w0 (
    .CLK(clk), .RST_N(rst_n), .CS(cs[1]), .WE(we[1]), .BE(be[1]), .ADDR(addr[1]),
    .Mem_Bus(bus1), .READY(ready[1]), .ERR(err[1])
  );

  typedef struct {
    string       name;
    bit          is_read;
    bit          err;
    logic [31:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int wc(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic logic [31:0] bus_of(input int k);
    return (k == 0) ? bus0 : bus1;
  endfunction

  // Undriven reads as Z in a four-state simulator and as 0 in a two-state one.
  // Either way a value that is neither means somebody is still driving.
  function automatic logic [31:0] released(input int k);
    logic [31:0] v;
    v = bus_of(k);
    return ($isunknown(v) || v == 32'h0) ? 32'd1 : 32'd0;
  endfunction

  task automatic push(input int k, input exp_t e);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic monitor(input int k);
    bit   prev = 1'b0;
    bit   empty;
    exp_t e;
    forever begin
      @(negedge clk);
      if (ready[k] && !prev) begin
        empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (empty) begin
          check($sformatf("dut%0d_unexpected_ready", k), 32'd1, 32'd0);
        end else begin
          if (k == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          check({e.name, "_err"}, 32'(err[k]), 32'(e.err));
          if (e.is_read) check({e.name, "_rdata"}, bus_of(k), e.data);
        end
      end
      prev = ready[k];
    end
  endtask

  // Full handshake. After acceptance, the pins are scrambled to show that
  // the latched values are the ones used.
  task automatic xact(input int k, input bit w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd_exp, input string tag);
    exp_t e;
    int   edges;
    e.name    = tag;
    e.is_read = !w;
    e.err     = (a >= 32'd128);
    e.data    = rd_exp;
    push(k, e);
    cs[k]   = 1'b1;
    we[k]   = w;
    be[k]   = b;
    addr[k] = a;
    if (w) begin
      mdrv[k] = wd;
      men[k]  = 1'b1;
    end
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      addr[k] = ~a;
      be[k]   = ~b;
      we[k]   = ~w;
      if (w) mdrv[k] = ~wd;
    end while (!ready[k] && edges < 20);
    check({tag, "_latency"}, 32'(edges), 32'(wc(k) + 1));
    @(negedge clk);
    #1;
    cs[k]  = 1'b0;
    men[k] = 1'b0;
    #1;
    check({tag, "_bus_released"}, released(k), 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_ready_err_clear"}, 32'({err[k], ready[k]}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   edges;
    rst_n = 1'b0;
    cs    = '0;
    we    = '0;
    men   = '0;
    for (int i = 0; i < 2; i++) begin
      be[i]   = '0;
      addr[i] = '0;
      mdrv[i] = '0;
    end
    fork
      monitor(0);
      monitor(1);
    join_none
    #12;
    check("reset_ready_err_w2", 32'({err[0], ready[0]}), 32'd0);
    check("reset_ready_err_w0", 32'({err[1], ready[1]}), 32'd0);
    check("reset_bus_w2", released(0), 32'd1);
    check("reset_bus_w0", released(1), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Wait-state timing and basic read-back.
    xact(0, 1'b1, 4'hF, 32'd3, 32'hDEADBEEF, 32'h0, "wr3");
    xact(0, 1'b0, 4'hF, 32'd3, 32'h0, 32'hDEADBEEF, "rd3");

    // Byte enables, including an all-zero no-op write.
    xact(0, 1'b1, 4'hF, 32'd7, 32'hAABBCCDD, 32'h0, "wr7_full");
    xact(0, 1'b1, 4'h1, 32'd7, 32'h00000011, 32'h0, "wr7_lane0");
    xact(0, 1'b1, 4'h8, 32'd7, 32'hFF000000, 32'h0, "wr7_lane3");
    xact(0, 1'b0, 4'hF, 32'd7, 32'h0, 32'hFFBBCC11, "rd7_merged");
    xact(0, 1'b1, 4'h0, 32'd7, 32'h12345678, 32'h0, "wr7_none");
    xact(0, 1'b0, 4'hF, 32'd7, 32'h0, 32'hFFBBCC11, "rd7_after_none");

    // Abort: CS drops after one WAIT edge, on the edge that would complete.
    xact(0, 1'b1, 4'hF, 32'd9, 32'h00000000, 32'h0, "wr9_zero");
    cs[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'd9;
    mdrv[0] = 32'h12345678; men[0] = 1'b1;
    @(posedge clk); #1;
    men[0] = 1'b0;
    check("abort_accept_no_ready", 32'(ready[0]), 32'd0);
    @(posedge clk); #1;
    check("abort_wait_no_ready", 32'(ready[0]), 32'd0);
    cs[0] = 1'b0;
    @(posedge clk); #1;
    check("abort_no_ready", 32'(ready[0]), 32'd0);
    xact(0, 1'b0, 4'hF, 32'd9, 32'h0, 32'h00000000, "rd9_after_abort");

    // Range errors. 200 aliases onto 72 and 128 onto 0 if the range check is lost.
    xact(0, 1'b1, 4'hF, 32'd0, 32'hA5A50000, 32'h0, "wr0");
    xact(0, 1'b1, 4'hF, 32'd72, 32'h72727272, 32'h0, "wr72");
    xact(0, 1'b0, 4'hF, 32'd128, 32'h0, 32'h00000000, "rd128_oor");
    xact(0, 1'b1, 4'hF, 32'd200, 32'hCAFEF00D, 32'h0, "wr200_oor");
    xact(0, 1'b0, 4'hF, 32'd0, 32'h0, 32'hA5A50000, "rd0_spot");
    xact(0, 1'b0, 4'hF, 32'd72, 32'h0, 32'h72727272, "rd72_spot");

    // Reset in the middle of a WAIT for a write: the write must not land.
    xact(0, 1'b1, 4'hF, 32'd5, 32'h11111111, 32'h0, "wr5");
    cs[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'd5;
    mdrv[0] = 32'h22222222; men[0] = 1'b1;
    @(posedge clk); #1;
    men[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_wait_ready_err", 32'({err[0], ready[0]}), 32'd0);
    check("rst_wait_bus", released(0), 32'd1);
    cs[0] = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xact(0, 1'b0, 4'hF, 32'd5, 32'h0, 32'h11111111, "rd5_after_rst");

    // Reset while in DONE: READY and the bus must drop with no clock edge.
    e.name = "rd5_done"; e.is_read = 1'b1; e.err = 1'b0; e.data = 32'h11111111;
    push(0, e);
    cs[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'd5;
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!ready[0] && edges < 20);
    check("rd5_done_latency", 32'(edges), 32'd3);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_done_ready", 32'(ready[0]), 32'd0);
    check("rst_done_bus", released(0), 32'd1);
    cs[0] = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero-wait instance.
    xact(1, 1'b1, 4'hF, 32'd1, 32'h0BADCAFE, 32'h0, "w0_wr1");
    xact(1, 1'b0, 4'hF, 32'd1, 32'h0, 32'h0BADCAFE, "w0_rd1");
    xact(1, 1'b0, 4'hF, 32'd130, 32'h0, 32'h00000000, "w0_rd130_oor");

    // CS held across several edges: exactly one READY rise, data held.
    e.name = "w0_hold"; e.is_read = 1'b1; e.err = 1'b0; e.data = 32'h0BADCAFE;
    push(1, e);
    cs[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'd1;
    @(posedge clk); #1;
    check("w0_first_edge_ready", 32'(ready[1]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("w0_hold_ready_%0d", i), 32'(ready[1]), 32'd1);
      check($sformatf("w0_hold_data_%0d", i), bus1, 32'h0BADCAFE);
    end
    cs[1] = 1'b0;
    #1;
    check("w0_hold_bus_released", released(1), 32'd1);
    @(posedge clk); #1;
    check("w0_idle_after_drop", 32'(ready[1]), 32'd0);
    e.name = "w0_next"; e.is_read = 1'b1; e.err = 1'b0; e.data = 32'h0BADCAFE;
    push(1, e);
    cs[1] = 1'b1;
    @(posedge clk); #1;
    check("w0_next_ready", 32'(ready[1]), 32'd1);
    @(negedge clk); #1;
    cs[1] = 1'b0;
    @(posedge clk); #1;

    #20;
    check("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
